// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, state and width definitions for the ALU operand loader
package alu_pkg;

    localparam int OPND_W = 4;
    localparam int OPC_W  = 3;

    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_NOT = 3'b010;
    localparam logic [OPC_W-1:0] OP_AND = 3'b011;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b100;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b101;
    localparam logic [OPC_W-1:0] OP_CMP = 3'b110;
    localparam logic [OPC_W-1:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OP   = 2'b10,
        S_HOLD = 2'b11
    } state_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// rtl/alu_operand_loader_if.sv - operand set handshake towards the ALU stage
interface alu_operand_loader_if;
    import alu_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [OPND_W-1:0] out_a;
    logic [OPND_W-1:0] out_b;
    logic [OPC_W-1:0]  out_op;
    logic [1:0]        phase;

    modport master (output out_valid, out_a, out_b, out_op, phase, input out_ready);
    modport slave  (input out_valid, out_a, out_b, out_op, phase, output out_ready);

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debounce (ALU_LOADER_DEBOUNCE_EN) and press edge detect
module btn_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic [1:0] sync;
    logic [1:0] seen;
    logic       armed;
    logic       level;
    logic       level_q;

    // armed stays low until a genuine low sample follows reset, so a button
    // held through reset release cannot produce a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b00;
            seen    <= 2'b00;
            armed   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            seen    <= {seen[0], 1'b1};
            armed   <= armed | (seen[1] & ~sync[1]);
            level_q <= level;
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync[1] != level) begin
            if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = DB_CYCLES + CNT_W;
    assign level      = sync[1];
`endif

    assign press = armed & level & ~level_q;

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - captures A, B and opcode from switches on button presses; ALU_LOADER_DEBOUNCE_EN enables debounce
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPND_W-1:0]    sw,
    input  logic                 btn,
    alu_operand_loader_if.master bus
);

    logic [OPND_W-1:0] sw_s1;
    logic [OPND_W-1:0] sw_s2;
    logic              press;
    state_t            state;
    state_t            state_nx;
    logic              cap_a;
    logic              cap_b;
    logic              cap_op;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            state <= S_A;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            state <= state_nx;
        end
    end

    // presses in S_HOLD fall through untouched, so a press during the handshake is dropped
    always_comb begin
        state_nx = state;
        cap_a    = 1'b0;
        cap_b    = 1'b0;
        cap_op   = 1'b0;
        case (state)
            S_A:    if (press) begin cap_a  = 1'b1; state_nx = S_B;    end
            S_B:    if (press) begin cap_b  = 1'b1; state_nx = S_OP;   end
            S_OP:   if (press) begin cap_op = 1'b1; state_nx = S_HOLD; end
            S_HOLD: if (bus.out_valid && bus.out_ready) state_nx = S_A;
            default: state_nx = S_A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_a     <= '0;
            bus.out_b     <= '0;
            bus.out_op    <= '0;
        end else begin
            bus.out_valid <= (state_nx == S_HOLD);
            if (cap_a)  bus.out_a  <= sw_s2;
            if (cap_b)  bus.out_b  <= sw_s2;
            if (cap_op) bus.out_op <= sw_s2[OPC_W-1:0];
        end
    end

    assign bus.phase = state;

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, meaning consecutive stable cycles required to accept a button level change (legal range 1..65535).
REQ-002 SHALL have parameter CNT_W, default 16, meaning debounce counter width.
REQ-003 Ports: clk  in  1  single clock, all state on its rising edge; reset is asynchronous and active-low (rst_n).
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: sw  in  4  raw slide switches, asynchronous.
REQ-006 Port: btn  in  1  raw push button, asynchronous, active-high, bouncy.
REQ-007 Port: out_ready  in  1  ALU stage accepts operand set.
REQ-008 Port: out_valid  out  1  operand set complete and stable.
REQ-009 Ports: out_a  out  4  operand A; out_b  out  4  operand B; out_op  out  3  ALU opcode.
REQ-010 Port: phase  out  2  current FSM state code, for LEDs.

Function
REQ-011 sw and btn SHALL each pass through a 2-flop synchronizer before use.
REQ-012 A press SHALL be a one-cycle pulse on the rising edge of the debounced button level; holding the button SHALL yield exactly one press.
REQ-013 With debounce, the level SHALL change only after the synchronized input differs from it for DB_CYCLES consecutive cycles; any glitch back resets the counter to 0.
REQ-014 Latency: btn held high from edge 1 (first edge sampling 1) SHALL capture on edge 3+DB_CYCLES.
REQ-015 FSM states/codes: S_A=00, S_B=01, S_OP=10, S_HOLD=11; phase equals state code.
REQ-016 S_A: press -> out_a<=sw, go S_B. S_B: press -> out_b<=sw, go S_OP. S_OP: press -> out_op<=sw[2:0], go S_HOLD.
REQ-017 out_valid SHALL be 1 exactly while in S_HOLD, registered, no combinational path from inputs.
REQ-018 S_HOLD: out_valid&&out_ready at an edge -> go S_A; out_valid low next cycle.
REQ-019 Presses in S_HOLD SHALL be ignored; press coinciding with handshake SHALL be dropped (handshake wins).
REQ-020 out_a/out_b/out_op SHALL be written only on their own capture and SHALL hold value otherwise, including after handshake.
REQ-021 out_a/out_b/out_op SHALL NOT change while out_valid=1.

Reset
REQ-022 rst_n low SHALL immediately force state S_A, out_valid=0, out_a=0, out_b=0, out_op=0, phase=00, debounce level=0, counter=0, synchronizers=0.
REQ-023 Reset mid-sequence SHALL discard partial operands; a button held through reset release SHALL NOT generate a press until released and pressed again.

Configuration
REQ-024 Macro ALU_LOADER_DEBOUNCE_EN defined: debounce counter per REQ-013 compiled in, latency per REQ-014.
REQ-025 Macro undefined: counter removed, debounced level equals synchronized btn, capture on edge 3; DB_CYCLES and CNT_W ignored.

Structure
REQ-026 Shared package alu_pkg SHALL hold opcode constants (ADD=000, SUB=001, NOT=010, AND=011, OR=100, XOR=101, CMP=110, EQ=111), FSM state codes, and operand/opcode widths (4, 3).
REQ-027 Synchronizer plus debounce plus edge detect SHALL be one sub-module, btn_debounce, instantiated once; FSM and output registers live in the top.

Verification (bench uses DB_CYCLES=4, macro defined unless stated)
REQ-028 sw=0011 press, sw=0101 press, sw=0000 press -> out_valid=1, out_a=3, out_b=5, out_op=000, phase=11; out_ready=1 -> out_valid=0, phase=00, out_a still 3.
REQ-029 btn pulses of 1-3 cycles, 10 times -> no capture, phase stays 00; btn held 200 cycles -> one capture only, phase 01.
REQ-030 btn high from edge 1 -> out_a updates on edge 7; macro undefined -> edge 3.
REQ-031 In S_HOLD with out_ready=0, press with sw=1111 -> out_a/out_b/out_op unchanged, out_valid stays 1; press same cycle as out_ready=1 -> phase 00 and no capture of out_a.
REQ-032 rst_n low during S_OP with out_a=9 -> outputs all 0 immediately, phase 00; btn held across release -> no capture until released and re-pressed.
